// File: rtl/plru_pkg.sv
// Shared types and tree-PLRU helper functions, written over a maximum tree depth
// so any power-of-2 associativity up to PLRU_MAX_WAYS can reuse them.
`default_nettype none

package plru_pkg;

   localparam int PLRU_MAX_LVL  = 6;
   localparam int PLRU_MAX_WAYS = 1 << PLRU_MAX_LVL;

   typedef logic [PLRU_MAX_WAYS-2:0] plru_tree_t;
   typedef logic [PLRU_MAX_LVL-1:0]  plru_way_t;

   typedef enum logic [0:0] {
      PLRU_IDLE  = 1'b0,
      PLRU_FLUSH = 1'b1
   } plru_state_e;

   // Heap-ordered tree: node n has children 2n+1 / 2n+2; way bits are consumed MSB first.
   function automatic plru_tree_t plru_update(input plru_tree_t tree, input plru_way_t way,
                                              input int levels);
      plru_tree_t               t;
      logic [PLRU_MAX_LVL:0]    node;
      logic [2:0]               bi;
      logic                     dir;
      t    = tree;
      node = '0;
      for (int l = 0; l < PLRU_MAX_LVL; l++) begin
         if (l < levels) begin
            bi   = 3'(levels - 1 - l);
            dir  = way[bi];
            t[node[PLRU_MAX_LVL-1:0]] = ~dir;
            node = (node << 1) + (PLRU_MAX_LVL+1)'(1) + {{PLRU_MAX_LVL{1'b0}}, dir};
         end
      end
      return t;
   endfunction

   function automatic plru_way_t plru_walk(input plru_tree_t tree, input int levels);
      plru_way_t                way;
      logic [PLRU_MAX_LVL:0]    node;
      logic                     dir;
      way  = '0;
      node = '0;
      for (int l = 0; l < PLRU_MAX_LVL; l++) begin
         if (l < levels) begin
            dir  = tree[node[PLRU_MAX_LVL-1:0]];
            way  = {way[PLRU_MAX_LVL-2:0], dir};
            node = (node << 1) + (PLRU_MAX_LVL+1)'(1) + {{PLRU_MAX_LVL{1'b0}}, dir};
         end
      end
      return way;
   endfunction

endpackage

`default_nettype wire

// File: rtl/plru_victim_sel.sv
// Victim selection: lowest invalid way wins, otherwise the tree walk of the set.
`default_nettype none

module plru_victim_sel
   import plru_pkg::*;
#(
   parameter int NUM_WAYS = 8,
   parameter int WAY_W    = $clog2(NUM_WAYS)
) (
   input  logic [NUM_WAYS-2:0] tree,
   input  logic [NUM_WAYS-1:0] valid_mask,
   output logic [WAY_W-1:0]    plru,
   output logic                victim_invalid
);

   logic [WAY_W-1:0] free_way;
   logic [WAY_W-1:0] walk_way;

   always_comb begin
      walk_way = WAY_W'(plru_walk(plru_tree_t'(tree), WAY_W));
      free_way = '0;
      // Descending scan so the lowest-numbered invalid way is the last assignment.
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!valid_mask[w]) free_way = WAY_W'(w);
      end
      victim_invalid = ~&valid_mask;
      plru           = victim_invalid ? free_way : walk_way;
   end

endmodule

`default_nettype wire

// File: rtl/plru_tree_param.sv
// Parametrised tree pseudo-LRU tracker: per-set tree storage, load/clear update
// path and a whole-array flush sequencer.
`default_nettype none

module plru_tree_param
   import plru_pkg::*;
#(
   parameter int NUM_WAYS = 8,
   parameter int NUM_SETS = 8,
   parameter int WAY_W    = $clog2(NUM_WAYS),
   parameter int IDX_W    = $clog2(NUM_SETS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IDX_W-1:0]    index,
   input  logic                load,
   input  logic [WAY_W-1:0]    last_access,
   input  logic                clear_set,
   input  logic [NUM_WAYS-1:0] valid_mask,
   input  logic                flush,
   output logic [WAY_W-1:0]    plru,
   output logic                victim_invalid,
   output logic                busy
);

   localparam int               TREE_W   = NUM_WAYS - 1;
   localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);

   logic [TREE_W-1:0] tree_q [NUM_SETS];
   plru_state_e       state;
   logic [IDX_W-1:0]  ctr;
   logic [TREE_W-1:0] cur_tree;
   logic [TREE_W-1:0] base_tree;
   logic [TREE_W-1:0] next_tree;

   assign cur_tree = tree_q[index];
   assign busy     = (state == PLRU_FLUSH);

   // Clear happens first so a simultaneous load lands on an all-zero tree.
   always_comb begin
      base_tree = clear_set ? '0 : cur_tree;
      next_tree = base_tree;
      if (load) begin
         next_tree = TREE_W'(plru_update(plru_tree_t'(base_tree),
                                         plru_way_t'(last_access), WAY_W));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < NUM_SETS; s++) tree_q[s] <= '0;
         state <= PLRU_IDLE;
         ctr   <= '0;
      end else begin
         case (state)
            PLRU_IDLE: begin
               if (load || clear_set) tree_q[index] <= next_tree;
               if (flush) begin
                  state <= PLRU_FLUSH;
                  ctr   <= '0;
               end
            end
            PLRU_FLUSH: begin
               tree_q[ctr] <= '0;
               if (ctr == LAST_SET) begin
                  state <= PLRU_IDLE;
                  ctr   <= '0;
               end else begin
                  ctr <= ctr + 1'b1;
               end
            end
            default: begin
               state <= PLRU_IDLE;
               ctr   <= '0;
            end
         endcase
      end
   end

   plru_victim_sel #(
      .NUM_WAYS (NUM_WAYS),
      .WAY_W    (WAY_W)
   ) u_victim_sel (
      .tree           (cur_tree),
      .valid_mask     (valid_mask),
      .plru           (plru),
      .victim_invalid (victim_invalid)
   );

endmodule

`default_nettype wire

// File: doc/plru_tree_param.md
Name: plru_tree_param

Overview:
- Parametrised tree pseudo-LRU replacement tracker for set-associative caches. Successor to the fixed 8-way/8-set tree.
- Holds NUM_WAYS-1 tree bits per set and reports the victim way for the addressed set.
- New over the fixed tree: invalid-way priority, per-set clear, and a multi-cycle whole-array flush sequencer with busy.
- Sits beside the tag/valid arrays in the I- and D-cache controllers.

Parameters:
NUM_WAYS, 8, associativity; power of 2, >= 2
NUM_SETS, 8, number of sets; >= 2
WAY_W, $clog2(NUM_WAYS), derived; not overridden
IDX_W, $clog2(NUM_SETS), derived; not overridden

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
index  in  IDX_W  set addressed for lookup, update and clear
load  in  1  record an access to last_access in set index at clk edge
last_access  in  WAY_W  way accessed (hit or fill)
clear_set  in  1  zero the tree bits of set index at clk edge
valid_mask  in  NUM_WAYS  valid bits of set index; bit w = way w valid
flush  in  1  start whole-array clear sequence
plru  out  WAY_W  victim way for set index (combinational)
victim_invalid  out  1  plru was chosen by invalid-way priority
busy  out  1  flush sequence in progress

Behaviour:
- Tree layout: node n has children 2n+1 and 2n+2. Leaves map to ways left to right. Tree bit 0 means the LRU side is the left subtree; 1 means the right subtree.
- Update: for each node on the path to last_access, set the bit to point away from that way (1 if the way is in the left subtree, else 0). Off-path bits are unchanged.
- Victim walk: start at the root and follow the bits to a leaf. The resulting way drives plru.
- Invalid priority: if valid_mask != all-ones, plru = lowest-numbered way with a 0 valid bit, and victim_invalid = 1. Otherwise plru is the tree walk and victim_invalid = 0.
- plru and victim_invalid are combinational from the current stored state of set index and valid_mask. Zero latency: an update at edge k is visible in plru after edge k.
- Reset (asynchronous, any time including mid-flush): all tree bits 0, FSM to IDLE, flush counter 0, busy = 0. With all ways valid, plru = 0 after reset.
- load and clear_set in the same cycle: the result is the access applied to an all-zero tree. Example, 8 ways, way 0: root=1, node1=1, node3=1, all other bits 0.
- A load to a set does not affect other sets.
- FSM IDLE:
  - flush=1 -> FLUSH with ctr=0.
  - load and clear_set on that same edge are still honoured.
- FSM FLUSH:
  - busy=1.
  - Each edge zeroes set ctr and increments ctr.
  - On the edge with ctr==NUM_SETS-1, zero that set and return to IDLE.
  - busy is high for exactly NUM_SETS cycles.
- During FLUSH:
  - load, clear_set and flush are ignored.
  - plru remains combinational from the stored state (may show partially cleared sets).
  - The counter wraps only by the return to IDLE. No access is lost silently; the caller must hold off while busy.
- Arithmetic: ctr is IDX_W bits; the terminal compare is against NUM_SETS-1, so non-power-of-2 NUM_SETS is legal. Index values >= NUM_SETS are illegal; the bench asserts against them.

Decomposition:
- Package plru_pkg:
  - FSM state enum (PLRU_IDLE, PLRU_FLUSH).
  - Functions plru_update(tree, way) and plru_walk(tree), written generically over NUM_WAYS via loops over tree levels.
- One sub-module: plru_victim_sel. Combinational; takes tree bits and valid_mask, returns plru and victim_invalid.
- Storage and FSM stay in plru_tree_param.

Test Plan:
- Reset, all valid, NUM_WAYS=8 -> plru=0 for every index; victim_invalid=0; busy=0.
- Set 3, load way 0 -> plru=4 on set 3; set 2 still plru=0. Then load way 4 -> plru=2. Then load way 2 -> plru=6.
- valid_mask=8'b1111_0111 on any set -> plru=3, victim_invalid=1. With 8'hFF -> plru is the tree walk.
- Set 5 in state root=1 (after a way-0 access), then clear_set with load way 7 in the same cycle -> root=0, node2=0, node6=0 -> plru=0.
- Load several sets, pulse flush -> busy high for exactly 8 cycles. Loads issued while busy have no effect. Afterwards all sets give plru=0.
- Assert rst mid-flush (cycle 3 of 8) -> busy drops immediately without a clk edge; all sets plru=0. Rerun the earlier scenarios at NUM_WAYS=4/NUM_SETS=16 and NUM_WAYS=16/NUM_SETS=5, comparing against a reference model.
